capp_ctrl: RTL and testbench

CAPP_CTRL -- requirements
Module: capp_ctrl

---
 rtl/capp_ctrl.sv | 154 +++++++++++++++
 tb/tb_capp_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/capp_ctrl.sv
// capp_ctrl: command sequencer for an associative (content-addressable) cell
// array. Accepts one command at a time, drives the array's search and write
// lines, keeps the tag register, and returns a one-cycle completion pulse.
//
// Ports
//   CLK, RST_N          clock, synchronous active-low reset
//   cmd_valid/ready     command handshake (ready only in IDLE)
//   cmd_op/data/mask    opcode, comparand/write value, bit-participation mask
//   tags                tag register driven to the array
//   mismatch_lines      search drive, {~d,d} per bit, active only in SRCH
//   write_lines         write drive, {reset,set} per bit, active only in WR
//   match_lines         per-cell mismatch from the array (1 = mismatch)
//   read_lines          OR of stored words over tagged cells
//   rsp_valid           one-cycle completion pulse
//   rsp_data/any/err    read result, |tags after the command, illegal opcode
module capp_ctrl #(
    parameter int num_bits  = 32,
    parameter int num_cells = 100
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [2:0]              cmd_op,
    input  logic [num_bits-1:0]     cmd_data,
    input  logic [num_bits-1:0]     cmd_mask,
    output logic [num_cells-1:0]    tags,
    output logic [2*num_bits-1:0]   mismatch_lines,
    output logic [2*num_bits-1:0]   write_lines,
    input  logic [num_cells-1:0]    match_lines,
    input  logic [num_bits-1:0]     read_lines,
    output logic                    rsp_valid,
    output logic [num_bits-1:0]     rsp_data,
    output logic                    rsp_any,
    output logic                    rsp_err
);

    localparam logic [2:0] OP_SET_ALL   = 3'd0;
    localparam logic [2:0] OP_SRCH_AND  = 3'd1;
    localparam logic [2:0] OP_SRCH_NEW  = 3'd2;
    localparam logic [2:0] OP_WRITE     = 3'd3;
    localparam logic [2:0] OP_READ      = 3'd4;
    localparam logic [2:0] OP_SEL_FIRST = 3'd5;
    localparam logic [2:0] OP_ANY       = 3'd6;

    typedef enum logic [2:0] {IDLE, SRCH, WR, SETTLE, RD} state_t;

    state_t                 state, state_nxt;
    logic [2:0]             op_q;
    logic [num_bits-1:0]    data_q, mask_q;
    logic [num_cells-1:0]   tags_nxt;
    logic [2*num_bits-1:0]  drive;
    logic                   done, err_nxt, rd_load, accept;

    assign cmd_ready = (state == IDLE);
    assign accept    = cmd_valid & cmd_ready;

    // Search and write share one encoding: even line follows the data bit,
    // odd line its complement; masked-off bits drive 00.
    always_comb begin
        drive = '0;
        for (int j = 0; j < num_bits; j++) begin
            drive[2*j]   = mask_q[j] &  data_q[j];
            drive[2*j+1] = mask_q[j] & ~data_q[j];
        end
    end

    always_comb begin
        state_nxt      = state;
        tags_nxt       = tags;
        done           = 1'b0;
        err_nxt        = 1'b0;
        rd_load        = 1'b0;
        mismatch_lines = '0;
        write_lines    = '0;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_SET_ALL: begin
                            tags_nxt = '1;
                            done     = 1'b1;
                        end
                        OP_SRCH_AND,
                        OP_SRCH_NEW: state_nxt = SRCH;
                        OP_WRITE:    state_nxt = WR;
                        OP_READ:     state_nxt = RD;
                        OP_SEL_FIRST: begin
                            // two's-complement trick isolates the lowest set bit
                            tags_nxt = tags & (~tags + num_cells'(1));
                            done     = 1'b1;
                        end
                        OP_ANY: done = 1'b1;
                        default: begin
                            done    = 1'b1;
                            err_nxt = 1'b1;
                        end
                    endcase
                end
            end
            SRCH: begin
                mismatch_lines = drive;
                tags_nxt  = (op_q == OP_SRCH_AND) ? (tags & ~match_lines) : ~match_lines;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            WR: begin
                write_lines = drive;
                state_nxt   = SETTLE;
            end
            // Array commits the store in two stages; hold drive low meanwhile.
            SETTLE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            RD: begin
                rd_load   = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state     <= IDLE;
            tags      <= '0;
            op_q      <= '0;
            data_q    <= '0;
            mask_q    <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_any   <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            tags      <= tags_nxt;
            rsp_valid <= done;
            if (accept) begin
                op_q   <= cmd_op;
                data_q <= cmd_data;
                mask_q <= cmd_mask;
            end
            if (done) begin
                rsp_any <= |tags_nxt;
                rsp_err <= err_nxt;
            end
            if (rd_load)
                rsp_data <= read_lines;
        end
    end

endmodule

// File: tb/tb_capp_ctrl.sv
// Bench for capp_ctrl (8-bit words, 4 cells). Contains a behavioural cell
// array driven by the DUT's lines, and a word-level reference model of the
// controller used for expected values.
module tb_capp_ctrl;
    localparam int NB = 8;
    localparam int NC = 4;

    logic            CLK = 1'b0;
    logic            RST_N = 1'b0;
    logic            cmd_valid = 1'b0;
    logic            cmd_ready;
    logic [2:0]      cmd_op = '0;
    logic [NB-1:0]   cmd_data = '0, cmd_mask = '0;
    logic [NC-1:0]   tags;
    logic [2*NB-1:0] mismatch_lines, write_lines;
    logic [NC-1:0]   match_lines;
    logic [NB-1:0]   read_lines;
    logic            rsp_valid, rsp_any, rsp_err;
    logic [NB-1:0]   rsp_data;

    always #5 CLK = ~CLK;

    capp_ctrl #(.num_bits(NB), .num_cells(NC)) dut (
        .CLK(CLK), .RST_N(RST_N), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_mask(cmd_mask), .tags(tags),
        .mismatch_lines(mismatch_lines), .write_lines(write_lines),
        .match_lines(match_lines), .read_lines(read_lines), .rsp_valid(rsp_valid),
        .rsp_data(rsp_data), .rsp_any(rsp_any), .rsp_err(rsp_err)
    );

    // ---------------- cell array environment ----------------
    logic [NB-1:0] arr [NC];
    logic [NB-1:0] load_val [NC];
    logic          load_req = 1'b0;

    always_comb begin
        match_lines = '0;
        read_lines  = '0;
        for (int i = 0; i < NC; i++) begin
            for (int j = 0; j < NB; j++)
                if ((mismatch_lines[2*j] & ~arr[i][j]) | (mismatch_lines[2*j+1] & arr[i][j]))
                    match_lines[i] = 1'b1;
            if (tags[i]) read_lines = read_lines | arr[i];
        end
    end

    always @(posedge CLK) begin
        if (load_req) begin
            for (int i = 0; i < NC; i++) arr[i] <= load_val[i];
        end else begin
            for (int i = 0; i < NC; i++)
                if (tags[i])
                    for (int j = 0; j < NB; j++) begin
                        if (write_lines[2*j])        arr[i][j] <= 1'b1;
                        else if (write_lines[2*j+1]) arr[i][j] <= 1'b0;
                    end
        end
    end

    // ---------------- reference model ----------------
    logic [NB-1:0] r_cells [NC];
    logic [NC-1:0] r_tags = '0;
    logic [NB-1:0] r_data = '0;

    function automatic int exp_lat(input logic [2:0] op);
        case (op)
            3'd1, 3'd2, 3'd4: return 2;
            3'd3:             return 3;
            default:          return 1;
        endcase
    endfunction

    function automatic logic [2*NB-1:0] exp_drive(input logic [NB-1:0] d, input logic [NB-1:0] m);
        logic [2*NB-1:0] v;
        v = '0;
        for (int j = 0; j < NB; j++)
            if (m[j]) begin
                v[2*j]   = d[j];
                v[2*j+1] = ~d[j];
            end
        return v;
    endfunction

    task automatic ref_apply(input logic [2:0] op, input logic [NB-1:0] d, input logic [NB-1:0] m);
        logic [NC-1:0] hit;
        logic          found;
        hit = '0;
        for (int i = 0; i < NC; i++) hit[i] = (((r_cells[i] ^ d) & m) == '0);
        case (op)
            3'd0: r_tags = '1;
            3'd1: r_tags = r_tags & hit;
            3'd2: r_tags = hit;
            3'd3: for (int i = 0; i < NC; i++)
                      if (r_tags[i]) r_cells[i] = (r_cells[i] & ~m) | (d & m);
            3'd4: begin
                r_data = '0;
                for (int i = 0; i < NC; i++) if (r_tags[i]) r_data = r_data | r_cells[i];
            end
            3'd5: begin
                found = 1'b0;
                for (int i = 0; i < NC; i++)
                    if (r_tags[i] && !found) found = 1'b1;
                    else r_tags[i] = 1'b0;
            end
            default: ;
        endcase
    endtask

    // ---------------- checking helpers ----------------
    int total = 0;
    int bad   = 0;
    int lat;
    logic [2*NB-1:0] ml1, wl1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic load_cells(input logic [NB-1:0] c0, c1, c2, c3);
        load_val[0] = c0; load_val[1] = c1; load_val[2] = c2; load_val[3] = c3;
        for (int i = 0; i < NC; i++) r_cells[i] = load_val[i];
        load_req = 1'b1;
        @(negedge CLK);
        load_req = 1'b0;
    endtask

    // Issue one command at a negedge, then wait (bounded) for rsp_valid.
    // With junk set, garbage commands are offered while the DUT is busy.
    task automatic run_cmd(input logic [2:0] op, input logic [NB-1:0] d,
                           input logic [NB-1:0] m, input bit junk);
        int n;
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(negedge CLK);
            n++;
        end
        cmd_valid = 1'b1; cmd_op = op; cmd_data = d; cmd_mask = m;
        @(negedge CLK);
        lat = 1;
        ml1 = mismatch_lines;
        wl1 = write_lines;
        while (!rsp_valid && lat < 10) begin
            if (junk) begin
                cmd_valid = 1'b1;
                cmd_op    = 3'($urandom);
                cmd_data  = NB'($urandom);
                cmd_mask  = NB'($urandom);
            end else begin
                cmd_valid = 1'b0;
            end
            @(negedge CLK);
            lat++;
        end
        cmd_valid = 1'b0;
    endtask

    task automatic check_rsp(input string nm, input logic [2:0] op, input logic [NB-1:0] d,
                             input logic [NB-1:0] m, input logic [NC-1:0] et,
                             input logic ea, input logic ee, input logic [NB-1:0] ed);
        chk({nm, ".lat"},  lat, exp_lat(op));
        chk({nm, ".tags"}, tags, et);
        chk({nm, ".any"},  rsp_any, ea);
        chk({nm, ".err"},  rsp_err, ee);
        chk({nm, ".data"}, rsp_data, ed);
        chk({nm, ".ml"},   ml1, (op == 3'd1 || op == 3'd2) ? exp_drive(d, m) : '0);
        chk({nm, ".wl"},   wl1, (op == 3'd3) ? exp_drive(d, m) : '0);
    endtask

    typedef struct {
        logic [2:0]    op;
        logic [NB-1:0] d, m;
        logic [NC-1:0] t;
        logic          a;
        logic [NB-1:0] rd;
    } vec_t;

    vec_t tbl [9];

    initial begin
        // ---- reset state ----
        repeat (3) @(negedge CLK);
        chk("rst.tags", tags, 0);
        chk("rst.valid", rsp_valid, 0);
        chk("rst.data", rsp_data, 0);
        chk("rst.any", rsp_any, 0);
        chk("rst.err", rsp_err, 0);
        chk("rst.ml", mismatch_lines, 0);
        chk("rst.wl", write_lines, 0);
        RST_N = 1'b1;
        @(negedge CLK);
        chk("rst.ready", cmd_ready, 1);
        chk("rst.novalid", rsp_valid, 0);

        // ---- write then read back on zeroed cells ----
        load_cells(8'h00, 8'h00, 8'h00, 8'h00);
        run_cmd(3'd0, 8'h00, 8'h00, 1'b0); ref_apply(3'd0, 8'h00, 8'h00);
        check_rsp("w.setall", 3'd0, 8'h00, 8'h00, 4'hF, 1'b1, 1'b0, 8'h00);
        run_cmd(3'd3, 8'hA5, 8'hFF, 1'b0); ref_apply(3'd3, 8'hA5, 8'hFF);
        chk("w.wl10", wl1[1:0], 2'b01);
        chk("w.wl32", wl1[3:2], 2'b10);
        check_rsp("w.write", 3'd3, 8'hA5, 8'hFF, 4'hF, 1'b1, 1'b0, 8'h00);
        run_cmd(3'd4, 8'h00, 8'h00, 1'b0); ref_apply(3'd4, 8'h00, 8'h00);
        check_rsp("w.read", 3'd4, 8'h00, 8'h00, 4'hF, 1'b1, 1'b0, 8'hA5);

        // ---- table: search, select, mask, no-match ----
        tbl[0] = '{3'd0, 8'h00, 8'h00, 4'b1111, 1'b1, 8'hA5};
        tbl[1] = '{3'd1, 8'h12, 8'hFF, 4'b0101, 1'b1, 8'hA5};
        tbl[2] = '{3'd5, 8'h00, 8'h00, 4'b0001, 1'b1, 8'hA5};
        tbl[3] = '{3'd2, 8'h30, 8'hF0, 4'b0010, 1'b1, 8'hA5};
        tbl[4] = '{3'd1, 8'hFF, 8'hFF, 4'b0000, 1'b0, 8'hA5};
        tbl[5] = '{3'd4, 8'h00, 8'h00, 4'b0000, 1'b0, 8'h00};
        tbl[6] = '{3'd6, 8'h00, 8'h00, 4'b0000, 1'b0, 8'h00};
        tbl[7] = '{3'd0, 8'h00, 8'h00, 4'b1111, 1'b1, 8'h00};
        tbl[8] = '{3'd4, 8'h00, 8'h00, 4'b1111, 1'b1, 8'h76};
        load_cells(8'h12, 8'h34, 8'h12, 8'h56);
        for (int k = 0; k < 9; k++) begin
            run_cmd(tbl[k].op, tbl[k].d, tbl[k].m, 1'b0);
            ref_apply(tbl[k].op, tbl[k].d, tbl[k].m);
            check_rsp($sformatf("tbl%0d", k), tbl[k].op, tbl[k].d, tbl[k].m,
                      tbl[k].t, tbl[k].a, 1'b0, tbl[k].rd);
        end
        chk("tbl.ml_lo", ml1[7:0], 0);

        // ---- reset during SETTLE aborts the WRITE ----
        cmd_valid = 1'b1; cmd_op = 3'd3; cmd_data = 8'h3C; cmd_mask = 8'h0F;
        @(negedge CLK);                // WR
        cmd_valid = 1'b0;
        @(negedge CLK);                // SETTLE
        chk("abort.settle_ready", cmd_ready, 0);
        RST_N = 1'b0;
        ref_apply(3'd3, 8'h3C, 8'h0F); // store already committed by the array
        r_tags = '0;
        r_data = '0;
        @(negedge CLK);
        chk("abort.novalid0", rsp_valid, 0);
        RST_N = 1'b1;
        @(negedge CLK);
        chk("abort.ready", cmd_ready, 1);
        chk("abort.novalid1", rsp_valid, 0);
        chk("abort.tags", tags, 0);
        chk("abort.data", rsp_data, 0);
        run_cmd(3'd7, 8'h55, 8'hFF, 1'b0);
        check_rsp("op7", 3'd7, 8'h55, 8'hFF, 4'h0, 1'b0, 1'b1, 8'h00);
        run_cmd(3'd7, 8'h00, 8'h00, 1'b0); ref_apply(3'd0, 8'h00, 8'h00);
        // op7 above must not disturb a following SET_ALL's clean err
        run_cmd(3'd0, 8'h00, 8'h00, 1'b0);
        check_rsp("post7", 3'd0, 8'h00, 8'h00, 4'hF, 1'b1, 1'b0, 8'h00);

        // ---- randomized against the reference model ----
        load_cells(8'h5A, 8'h5A, 8'hC3, 8'h0F);
        for (int k = 0; k < 300; k++) begin
            logic [2:0]    op;
            logic [NB-1:0] d, m;
            bit            junk;
            op = 3'($urandom_range(0, 7));
            d  = ($urandom_range(0, 1) == 0) ? r_cells[$urandom_range(0, NC-1)] : NB'($urandom);
            case ($urandom_range(0, 2))
                0:       m = 8'hFF;
                1:       m = 8'hF0;
                default: m = NB'($urandom);
            endcase
            junk = bit'($urandom_range(0, 1));
            run_cmd(op, d, m, junk);
            ref_apply(op, d, m);
            check_rsp($sformatf("rnd%0d", k), op, d, m, r_tags, |r_tags, op == 3'd7, r_data);
            if ($urandom_range(0, 3) == 0) begin
                @(negedge CLK);
                chk("rnd.pulse1", rsp_valid, 0);
                chk("rnd.ready", cmd_ready, 1);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
